// File: rtl/dram_access_ctrl.sv
// DRAM access controller: turns byte/half/word loads and stores into 32-bit backend transactions.
// Optional feature macro: DRAM_WSTRB_EN (adds mem_wstrb, sub-word stores become single strobed writes).
module dram_access_ctrl #(
    parameter int unsigned ADDR_W = 26
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              w_dram_le,
    input  logic [31:0]       w_dram_addr,
    input  logic [31:0]       w_dram_wdata,
    input  logic              w_dram_we_t,
    input  logic [2:0]        w_dram_ctrl,
    output logic [31:0]       w_dram_odata,
    output logic              w_dram_busy,
    output logic              w_dram_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
`ifdef DRAM_WSTRB_EN
    ,
    output logic [3:0]        mem_wstrb
`endif
);

    localparam int unsigned LANE_W = 2;
    localparam int unsigned HALF_W = 16;
    localparam logic [1:0]  SZ_B   = 2'b00;
    localparam logic [1:0]  SZ_H   = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ
    } state_t;

    state_t             state;
    logic [LANE_W-1:0]  lane_q;
    logic [2:0]         ctrl_q;
    logic               we_q;
`ifndef DRAM_WSTRB_EN
    logic [HALF_W-1:0]  wdata_q;
`endif

    logic               req_bad;
    logic               direct_wr;
    logic [31:0]        st_data;
`ifdef DRAM_WSTRB_EN
    logic [3:0]         st_strb;
`endif

    // Upper byte-address bits beyond the backend word address are not decoded.
    logic unused_addr_hi;
    assign unused_addr_hi = ^w_dram_addr[31:ADDR_W+2];

    // Extract the addressed lane and extend it according to funct3.
    function automatic logic [31:0] load_ext(input logic [31:0] w,
                                             input logic [LANE_W-1:0] lane,
                                             input logic [2:0] f);
        logic [7:0]        b;
        logic [HALF_W-1:0] h;
        logic [31:0]       r;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lane[1] ? w[31:16] : w[15:0];
        case (f)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

`ifndef DRAM_WSTRB_EN
    // Replace the addressed byte/half of the read word with the store data.
    function automatic logic [31:0] merge_lane(input logic [31:0] w,
                                               input logic [HALF_W-1:0] d,
                                               input logic [LANE_W-1:0] lane,
                                               input logic half);
        logic [31:0] m;
        m = w;
        if (half) begin
            if (lane[1]) m[31:16] = d;
            else         m[15:0]  = d;
        end else begin
            case (lane)
                2'd0:    m[7:0]   = d[7:0];
                2'd1:    m[15:8]  = d[7:0];
                2'd2:    m[23:16] = d[7:0];
                default: m[31:24] = d[7:0];
            endcase
        end
        return m;
    endfunction
`endif

    // Launch-time legality check and store payload formatting.
    always_comb begin
        req_bad   = 1'b0;
        direct_wr = 1'b0;
        st_data   = w_dram_wdata;
`ifdef DRAM_WSTRB_EN
        st_strb   = 4'b1111;
`endif
        case (w_dram_ctrl)
            3'b011, 3'b110, 3'b111: req_bad = 1'b1;
            3'b001, 3'b101:         req_bad = w_dram_addr[0];
            3'b010:                 req_bad = |w_dram_addr[1:0];
            default:                req_bad = 1'b0;
        endcase
`ifdef DRAM_WSTRB_EN
        direct_wr = 1'b1;
        case (w_dram_ctrl[1:0])
            SZ_B: begin
                st_data = {4{w_dram_wdata[7:0]}};
                st_strb = 4'(4'b0001 << w_dram_addr[1:0]);
            end
            SZ_H: begin
                st_data = {2{w_dram_wdata[15:0]}};
                st_strb = w_dram_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_data = w_dram_wdata;
                st_strb = 4'b1111;
            end
        endcase
`else
        direct_wr = (w_dram_ctrl[1:0] != SZ_B) && (w_dram_ctrl[1:0] != SZ_H);
`endif
    end

    // Request FSM with registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            w_dram_busy  <= 1'b0;
            w_dram_err   <= 1'b0;
            w_dram_odata <= '0;
            lane_q       <= '0;
            ctrl_q       <= '0;
            we_q         <= 1'b0;
`ifdef DRAM_WSTRB_EN
            mem_wstrb    <= '0;
`else
            wdata_q      <= '0;
`endif
        end else begin
            w_dram_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (w_dram_le) begin
                        if (req_bad) begin
                            w_dram_err <= 1'b1;
                        end else begin
                            lane_q      <= w_dram_addr[1:0];
                            ctrl_q      <= w_dram_ctrl;
                            we_q        <= w_dram_we_t;
`ifndef DRAM_WSTRB_EN
                            wdata_q     <= w_dram_wdata[15:0];
`endif
                            mem_addr    <= w_dram_addr[ADDR_W+1:2];
                            mem_req     <= 1'b1;
                            w_dram_busy <= 1'b1;
                            if (w_dram_we_t && direct_wr) begin
                                mem_we    <= 1'b1;
                                mem_wdata <= st_data;
`ifdef DRAM_WSTRB_EN
                                mem_wstrb <= st_strb;
`endif
                                state     <= WR_REQ;
                            end else begin
                                mem_we    <= 1'b0;
`ifdef DRAM_WSTRB_EN
                                mem_wstrb <= 4'b0000;
`endif
                                state     <= RD_REQ;
                            end
                        end
                    end
                end
                RD_REQ: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (mem_rvalid) begin
`ifdef DRAM_WSTRB_EN
                        w_dram_odata <= load_ext(mem_rdata, lane_q, ctrl_q);
                        w_dram_busy  <= 1'b0;
                        state        <= IDLE;
`else
                        if (we_q) begin
                            mem_wdata <= merge_lane(mem_rdata, wdata_q, lane_q, ctrl_q[0]);
                            mem_we    <= 1'b1;
                            mem_req   <= 1'b1;
                            state     <= WR_REQ;
                        end else begin
                            w_dram_odata <= load_ext(mem_rdata, lane_q, ctrl_q);
                            w_dram_busy  <= 1'b0;
                            state        <= IDLE;
                        end
`endif
                    end
                end
                WR_REQ: begin
                    if (mem_ready) begin
                        mem_req     <= 1'b0;
                        mem_we      <= 1'b0;
`ifdef DRAM_WSTRB_EN
                        mem_wstrb   <= 4'b0000;
`endif
                        w_dram_busy <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    mem_req     <= 1'b0;
                    mem_we      <= 1'b0;
                    w_dram_busy <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
